// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: resolves one 2-bit digit per clock, MSB digit first.
// Optional build macro SEQ_MAG_COMP_EARLY_EXIT_EN finishes on the first deciding digit.
//
// state | meaning
// IDLE  | no compare issued since reset
// RUN   | walking digits from NDIG-1 down to 0
// DONE  | result held on eq/gt/lt until the next accepted start
module seq_mag_comp #(
    parameter  int WIDTH = 32,
    localparam int NDIG  = WIDTH / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             casc_eq_q;
    logic             casc_gt_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic [WIDTH-1:0] msb_flip;
    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [1:0]       ad;
    logic [1:0]       bd;
    logic             casc_eq_d;
    logic             casc_gt_d;
    logic             finish_d;

    // Offset-binary mapping turns the signed compare into an unsigned one.
    always_comb begin
        msb_flip            = '0;
        msb_flip[WIDTH-1]   = sgn_q;
        a_cmp               = a_q ^ msb_flip;
        b_cmp               = b_q ^ msb_flip;
        ad                  = a_cmp[{idx_q, 1'b0} +: 2];
        bd                  = b_cmp[{idx_q, 1'b0} +: 2];
        casc_eq_d           = casc_eq_q;
        casc_gt_d           = casc_gt_q;
        if (casc_eq_q) begin
            casc_eq_d = (ad == bd);
            casc_gt_d = (ad > bd);
        end
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        finish_d = (idx_q == '0) || !casc_eq_d;
`else
        finish_d = (idx_q == '0);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            casc_eq_q <= 1'b1;
            casc_gt_q <= 1'b0;
            idx_q     <= IW'(NDIG - 1);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        sgn_q     <= is_signed;
                        casc_eq_q <= 1'b1;
                        casc_gt_q <= 1'b0;
                        idx_q     <= IW'(NDIG - 1);
                        busy_q    <= 1'b1;
                        eq_q      <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here; the compare in flight runs to completion.
                    casc_eq_q <= casc_eq_d;
                    casc_gt_q <= casc_gt_d;
                    idx_q     <= idx_q - IW'(1);
                    if (finish_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        eq_q    <= casc_eq_d;
                        gt_q    <= casc_gt_d;
                        lt_q    <= !casc_eq_d && !casc_gt_d;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp (WIDTH=8): directed cases plus randomized compares
// checked against an arithmetic reference model.
module tb_seq_mag_comp;

    localparam int WIDTH = 8;
    localparam int NDIG  = WIDTH / 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    int   checks = 0;
    int   errors = 0;
    int   exp_lat;
    logic exp_eq;
    logic exp_gt;
    logic exp_lt;

    seq_mag_comp #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer compare; latency from the first differing digit.
    task automatic set_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic sv);
        logic [WIDTH-1:0] diff;
        a         = av;
        b         = bv;
        is_signed = sv;
        start     = 1'b1;
        if (sv) exp_gt = ($signed(av) > $signed(bv));
        else    exp_gt = (av > bv);
        exp_eq  = (av == bv);
        exp_lt  = !exp_eq && !exp_gt;
        exp_lat = NDIG;
        diff    = av ^ bv;
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        for (int d = 0; d < NDIG; d++)
            if (((diff >> (2 * d)) & 8'h3) != 0) exp_lat = NDIG - d;
`else
        if (diff == 0) exp_lat = NDIG;
`endif
    endtask

    // Cycle 0: just after the start edge. Scramble inputs to prove they were latched.
    task automatic post_start();
        @(negedge clock);
        start     = 1'b0;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        is_signed = 1'($urandom);
        chk("busy_c0", busy, 1);
        chk("done_c0", done, 0);
        chk("eq_c0", eq, 0);
        chk("gt_c0", gt, 0);
        chk("lt_c0", lt, 0);
    endtask

    task automatic finish_cmp(input int pulse_at);
        for (int k = 1; k <= exp_lat; k++) begin
            @(negedge clock);
            if (k == pulse_at + 1) start = 1'b0;
            chk("done_cyc", done, 32'(k == exp_lat));
            chk("busy_cyc", busy, 32'(k < exp_lat));
            if (k == exp_lat) begin
                chk("eq_res", eq, exp_eq);
                chk("gt_res", gt, exp_gt);
                chk("lt_res", lt, exp_lt);
            end
            if (k == pulse_at) begin
                a     = 8'hFF;
                b     = 8'h00;
                start = 1'b1;
            end
        end
    endtask

    task automatic hold_check(input int n);
        repeat (n) begin
            @(negedge clock);
            chk("done_hold", done, 0);
            chk("busy_hold", busy, 0);
            chk("eq_hold", eq, exp_eq);
            chk("gt_hold", gt, exp_gt);
            chk("lt_hold", lt, exp_lt);
        end
    endtask

    task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic sv);
        set_start(av, bv, sv);
        post_start();
        finish_cmp(0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_eq", eq, 0);
        chk("rst_gt", gt, 0);
        chk("rst_lt", lt, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        run_cmp(8'hA5, 8'hA5, 1'b0);
        hold_check(3);
        run_cmp(8'h80, 8'h7F, 1'b0);
        hold_check(1);
        run_cmp(8'h80, 8'h7F, 1'b1);
        hold_check(1);
        run_cmp(8'h40, 8'h00, 1'b0);
        hold_check(1);

        // Start pulsed while busy must be ignored.
        set_start(8'h01, 8'h02, 1'b0);
        post_start();
        finish_cmp(1);
        hold_check(2);

        // Reset mid-run aborts without a done pulse.
        set_start(8'h10, 8'h20, 1'b0);
        post_start();
        @(negedge clock);
        chk("busy_pre_rst", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_eq", eq, 0);
        chk("abort_gt", gt, 0);
        chk("abort_lt", lt, 0);
        repeat (3) begin
            @(negedge clock);
            chk("abort_nodone", done, 0);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        run_cmp(8'hFE, 8'hFF, 1'b1);
        hold_check(1);

        // Start in the done cycle is accepted back-to-back.
        run_cmp(8'h12, 8'h34, 1'b0);
        set_start(8'h33, 8'h33, 1'b0);
        post_start();
        finish_cmp(0);
        hold_check(1);

        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            run_cmp(ra, rb, 1'($urandom));
            if ($urandom_range(0, 1) == 1) hold_check(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands.
- Resolves one 2-bit digit per clock, MSB digit first, through a registered EQ/GT cascade.
- Supports unsigned and two's-complement signed compare, with a start/done handshake.
- Used by the branch/compare path where a single-cycle full-width comparator does not meet timing.

Parameters:
- WIDTH, 32: operand width in bits; must be even and >= 2.
- NDIG, WIDTH/2: number of 2-bit digits (derived; not overridden).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a compare; sampled only in IDLE or DONE.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result becomes valid.
- eq  out  1  A == B.
- gt  out  1  A > B.
- lt  out  1  A < B.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - busy, done, eq, gt, lt all 0.
  - Internal cascade EQ = 1, GT = 0; digit index = NDIG-1.
- States:
  - IDLE: start = 1 at an edge -> RUN.
  - RUN: processes one digit per cycle.
  - DONE: result held. start = 1 at an edge -> RUN; otherwise stay in DONE.
- Start edge actions:
  - Latch a, b and is_signed.
  - Set cascade EQ = 1, GT = 0, idx = NDIG-1.
  - busy = 1 from the next cycle.
  - eq, gt and lt are cleared to 0 at the start edge.
- Signed handling:
  - If the latched is_signed = 1, bit WIDTH-1 of both latched operands is inverted before comparison.
  - This offset-binary mapping makes the unsigned compare equal to the signed compare.
- Each RUN edge applies digit idx (Ad = A[2idx+1:2idx], Bd likewise):
  - If EQ: EQ' = (Ad == Bd); GT' = (Ad > Bd).
  - If not EQ: EQ and GT hold.
  - idx decrements.
- Termination:
  - The edge that processes idx = 0 moves to DONE.
  - busy falls and done pulses high for exactly one cycle.
  - eq = EQ', gt = GT', lt = !EQ' & !GT'.
- Latency: done is high in cycle NDIG after the start edge (start edge = cycle 0). With WIDTH = 8, done is high in cycle 4.
- Results: eq, gt and lt are exactly one-hot while in DONE and remain stable until the next accepted start.
- start while busy: ignored; the operation in progress is unaffected.
- start in the same cycle as done: accepted. The result pulses and the new compare starts back-to-back.
- Reset mid-RUN: immediate abort to the reset state; no done pulse is produced.

Optional Feature:
- Macro: SEQ_MAG_COMP_EARLY_EXIT_EN.
- Defined:
  - If a RUN edge produces EQ' = 0, the FSM goes to DONE on that edge regardless of idx.
  - done is high in cycle (NDIG - idx) after the start edge, where idx is the deciding digit.
  - Equal operands still take NDIG cycles.
- Undefined:
  - Latency is always NDIG cycles.
  - Remaining digits are processed with the cascade already frozen.
- Results are identical in both builds; only the timing of done differs.

Test Plan:
- WIDTH=8, a=0xA5, b=0xA5, is_signed=0, start pulse -> busy high in cycles 1-3; done high in cycle 4 only; eq=1, gt=0, lt=0 held until the next start.
- a=0x80, b=0x7F, is_signed=0 -> gt=1, lt=0, eq=0. Repeat with is_signed=1 -> lt=1, gt=0, eq=0.
- a=0x40, b=0x00, is_signed=0:
  - With SEQ_MAG_COMP_EARLY_EXIT_EN: done in cycle 1, gt=1.
  - Without it: done in cycle 4, gt=1.
- Start a=0x01, b=0x02, then pulse start again at cycle 2 with a=0xFF, b=0x00 -> second start ignored; done in cycle 4 with lt=1.
- Start a=0x10, b=0x20, then drive reset low at cycle 2 -> busy, done, eq, gt, lt = 0 immediately; no done pulse. Release reset, start a=0xFE, b=0xFF with is_signed=1 -> done in cycle 4 with lt=1.
- Raise start in the same cycle done pulses, with a=0x33, b=0x33 -> new compare accepted; prior result visible for that cycle; eq=1 four cycles later.
